// File: rtl/lcd_defs.sv
// Shared LCD state-machine definitions.
// The state codes are reused by the LCD state machine and by everything that
// watches it. The clamp helpers are unsigned saturating limits for the write
// region.
package lcd_defs;

    localparam logic [7:0] LCD_IDLE  = 8'h00;
    localparam logic [7:0] LCD_WRITE = 8'h01;
    localparam logic [7:0] LCD_ERROR = 8'hFF;

    function automatic logic [7:0] clamp_u8(input logic [7:0] value, input logic [7:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    function automatic logic [3:0] clamp_u4(input logic [3:0] value, input logic [3:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin arbiter.
// It scans upward from the pointer, wrapping around, and returns the first
// active request. The result is a one-hot winner plus its binary index.
// Both outputs are zero when no request is set.
module lcd_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    localparam logic [IDX_W:0] NUM_C = (IDX_W+1)'(NUM_REQ);

    logic           found_s;
    logic [IDX_W:0] cand_s;

    // Find the first set request at or above the pointer, modulo NUM_REQ
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found_s    = 1'b0;
        cand_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = {1'b0, pointer} + (IDX_W+1)'(i);
            if (cand_s >= NUM_C) begin
                cand_s = cand_s - NUM_C;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                found_s    = 1'b1;
                winner_idx = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            winner[winner_idx] = 1'b1;
        end else begin
            winner = '0;
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// LCD write scheduler: shares the LCD write path between NUM_REQ producers.
//
// Operation:
//   - Waits for the LCD state machine to report IDLE.
//   - Grants one requester round-robin and loads its clamped column/line limits.
//   - Pulses lcd_advance to start the write.
//   - Follows the LCD through WRITE and back to IDLE, then pulses done.
//   - A stall in any wait state (timer) or an LCD ERROR code aborts the
//     refresh and sets the sticky timeout_err.
//
// Optional build macro:
//   LCD_SCHED_URGENT_EN - requester 0 wins whenever it requests, and its
//                         grants leave the round-robin pointer untouched.
module lcd_write_scheduler
    import lcd_defs::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int COL_MAX  = 129,
    parameter int LINE_MAX = 8,
    parameter int TIMEOUT  = 4095
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_column,
    input  logic [NUM_REQ*4-1:0] req_line,
    input  logic [7:0]           lcd_state,
    output logic [7:0]           column_write,
    output logic [3:0]           line_write,
    output logic                 lcd_advance,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [7:0]       COL_MAX_C  = 8'(COL_MAX);
    localparam logic [3:0]       LINE_MAX_C = 4'(LINE_MAX);
    localparam logic [11:0]      TIMEOUT_C  = 12'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADV       = 3'd1,
        S_WAIT_WR   = 3'd2,
        S_WAIT_RUN  = 3'd3,
        S_WAIT_IDLE = 3'd4
    } sched_state_e;

    sched_state_e       state_r, state_next_s;
    logic [IDX_W-1:0]   ptr_r, ptr_next_s, ptr_after_s;
    logic [IDX_W-1:0]   act_idx_r;
    logic               urgent_r;
    logic [11:0]        timer_r, timer_next_s;
    logic [NUM_REQ-1:0] arb_winner_s, sel_winner_s;
    logic [IDX_W-1:0]   arb_idx_s, sel_idx_s;
    logic               sel_urgent_s;
    logic [7:0]         col_pick_s;
    logic [3:0]         line_pick_s;
    logic               load_s, abort_s, adv_next_s;
    logic [NUM_REQ-1:0] grant_next_s, done_next_s;

    lcd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .pointer    (ptr_r),
        .winner     (arb_winner_s),
        .winner_idx (arb_idx_s)
    );

    // Final winner: round-robin result, optionally overridden by urgent requester 0
    always_comb begin
`ifdef LCD_SCHED_URGENT_EN
        if (req[0]) begin
            sel_winner_s = {{(NUM_REQ-1){1'b0}}, 1'b1};
            sel_idx_s    = '0;
            sel_urgent_s = 1'b1;
        end else begin
            sel_winner_s = arb_winner_s;
            sel_idx_s    = arb_idx_s;
            sel_urgent_s = 1'b0;
        end
`else
        sel_winner_s = arb_winner_s;
        sel_idx_s    = arb_idx_s;
        sel_urgent_s = 1'b0;
`endif
    end

    // Extract the winner's raw column/line request fields
    always_comb begin
        col_pick_s  = 8'd0;
        line_pick_s = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx_s == IDX_W'(i)) begin
                col_pick_s  = req_column[8*i +: 8];
                line_pick_s = req_line[4*i +: 4];
            end else begin
                col_pick_s  = col_pick_s;
                line_pick_s = line_pick_s;
            end
        end
    end

    // Next-state, timer and pulse decode for the scheduler FSM
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        ptr_next_s   = ptr_r;
        grant_next_s = '0;
        done_next_s  = '0;
        adv_next_s   = 1'b0;
        load_s       = 1'b0;
        abort_s      = 1'b0;

        // Pointer after this refresh ends; urgent grants leave it alone
        if (urgent_r) begin
            ptr_after_s = ptr_r;
        end else if (act_idx_r == LAST_IDX_C) begin
            ptr_after_s = '0;
        end else begin
            ptr_after_s = act_idx_r + IDX_W'(1);
        end

        case (state_r)
            S_IDLE: begin
                if ((lcd_state == LCD_IDLE) && (|req)) begin
                    load_s       = 1'b1;
                    grant_next_s = sel_winner_s;
                    state_next_s = S_ADV;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ADV: begin
                if (lcd_state == LCD_ERROR) begin
                    abort_s = 1'b1;
                end else begin
                    adv_next_s   = 1'b1;
                    timer_next_s = 12'd0;
                    state_next_s = S_WAIT_WR;
                end
            end
            S_WAIT_WR: begin
                if (lcd_state == LCD_ERROR) begin
                    abort_s = 1'b1;
                end else if (lcd_state == LCD_WRITE) begin
                    timer_next_s = 12'd0;
                    state_next_s = S_WAIT_RUN;
                end else if (timer_r == TIMEOUT_C) begin
                    abort_s = 1'b1;
                end else begin
                    timer_next_s = timer_r + 12'd1;
                end
            end
            S_WAIT_RUN: begin
                if (lcd_state == LCD_ERROR) begin
                    abort_s = 1'b1;
                end else if (lcd_state != LCD_WRITE) begin
                    timer_next_s = 12'd0;
                    state_next_s = S_WAIT_IDLE;
                end else if (timer_r == TIMEOUT_C) begin
                    abort_s = 1'b1;
                end else begin
                    timer_next_s = timer_r + 12'd1;
                end
            end
            S_WAIT_IDLE: begin
                if (lcd_state == LCD_ERROR) begin
                    abort_s = 1'b1;
                end else if (lcd_state == LCD_IDLE) begin
                    done_next_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << act_idx_r;
                    ptr_next_s   = ptr_after_s;
                    timer_next_s = 12'd0;
                    state_next_s = S_IDLE;
                end else if (timer_r == TIMEOUT_C) begin
                    abort_s = 1'b1;
                end else begin
                    timer_next_s = timer_r + 12'd1;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase

        // Abort: back to idle without done; column/line keep their values
        if (abort_s) begin
            state_next_s = S_IDLE;
            ptr_next_s   = ptr_after_s;
            timer_next_s = 12'd0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, pointer, timer and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_IDLE;
            ptr_r        <= '0;
            act_idx_r    <= '0;
            urgent_r     <= 1'b0;
            timer_r      <= 12'd0;
            column_write <= 8'd0;
            line_write   <= 4'd0;
            lcd_advance  <= 1'b0;
            grant        <= '0;
            done         <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ptr_r       <= ptr_next_s;
            timer_r     <= timer_next_s;
            lcd_advance <= adv_next_s;
            grant       <= grant_next_s;
            done        <= done_next_s;
            busy        <= (state_next_s != S_IDLE);
            timeout_err <= timeout_err | abort_s;
            if (load_s) begin
                column_write <= clamp_u8(col_pick_s, COL_MAX_C);
                line_write   <= clamp_u4(line_pick_s, LINE_MAX_C);
                act_idx_r    <= sel_idx_s;
                urgent_r     <= sel_urgent_s;
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Self-checking bench for lcd_write_scheduler.
// A transaction-level reference model predicts every output each cycle.
// Directed scenarios add literal expectations on top of the model.
module tb_lcd_write_scheduler;
    import lcd_defs::*;

    localparam int NREQ      = 3;
    localparam int COL_MAX   = 129;
    localparam int LINE_MAX  = 8;
    localparam int TIMEOUT   = 4095;
    localparam logic [7:0] LCD_DISP0 = 8'h02;
`ifdef LCD_SCHED_URGENT_EN
    localparam int URGENT = 1;
`else
    localparam int URGENT = 0;
`endif

    logic             clock;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ*8-1:0] req_column;
    logic [NREQ*4-1:0] req_line;
    logic [7:0]       lcd_state;
    logic [7:0]       column_write;
    logic [3:0]       line_write;
    logic             lcd_advance;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic             timeout_err;

    lcd_write_scheduler #(
        .NUM_REQ  (NREQ),
        .COL_MAX  (COL_MAX),
        .LINE_MAX (LINE_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_column   (req_column),
        .req_line     (req_line),
        .lcd_state    (lcd_state),
        .column_write (column_write),
        .line_write   (line_write),
        .lcd_advance  (lcd_advance),
        .grant        (grant),
        .done         (done),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model ----------------
    // A refresh has four steps after the grant:
    //   granted  -> advance issued -> write seen -> write left -> idle (done)
    localparam int ST_GRANTED = 0, ST_ADVANCED = 1, ST_WRITING = 2, ST_DRAINING = 3;
    int          m_valid = 0, m_act, m_ptr, m_urg, m_owner, m_step, m_cnt;
    int          w, cv, lv, hit, fin_ok, fin_ab;
    logic        s_rst;
    logic [NREQ-1:0]   s_req;
    logic [7:0]        s_lst;
    logic [NREQ*8-1:0] s_col;
    logic [NREQ*4-1:0] s_line;
    logic [NREQ-1:0]   e_grant, e_done;
    logic              e_adv, e_busy, e_err;
    logic [7:0]        e_col;
    logic [3:0]        e_line;

    // Predict outputs from inputs seen at each edge, compare just after it
    always @(posedge clock) begin
        s_rst = reset; s_req = req; s_lst = lcd_state; s_col = req_column; s_line = req_line;
        if (s_rst) begin
            m_valid = 1; m_act = 0; m_ptr = 0; m_urg = 0; m_owner = 0; m_step = 0; m_cnt = 0;
            e_grant = '0; e_done = '0; e_adv = 1'b0; e_busy = 1'b0;
            e_col = 8'd0; e_line = 4'd0; e_err = 1'b0;
        end else begin
            e_grant = '0; e_done = '0; e_adv = 1'b0;
            if (m_act == 0) begin
                if (s_lst == LCD_IDLE && s_req != '0) begin
                    w = -1; m_urg = 0;
                    if (URGENT != 0 && s_req[0]) begin
                        w = 0; m_urg = 1;
                    end else begin
                        for (int k = 0; k < NREQ; k++)
                            if (w < 0 && s_req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                    end
                    m_owner = w;
                    e_grant[w] = 1'b1;
                    cv = int'(s_col[w*8 +: 8]);
                    lv = int'(s_line[w*4 +: 4]);
                    e_col  = 8'((cv > COL_MAX) ? COL_MAX : cv);
                    e_line = 4'((lv > LINE_MAX) ? LINE_MAX : lv);
                    m_act = 1; m_step = ST_GRANTED; m_cnt = 0;
                end
            end else begin
                fin_ok = 0; fin_ab = 0;
                if (s_lst == LCD_ERROR) fin_ab = 1;
                else if (m_step == ST_GRANTED) begin
                    e_adv = 1'b1; m_step = ST_ADVANCED; m_cnt = 0;
                end else begin
                    hit = ((m_step == ST_ADVANCED) && (s_lst == LCD_WRITE)) ||
                          ((m_step == ST_WRITING)  && (s_lst != LCD_WRITE)) ||
                          ((m_step == ST_DRAINING) && (s_lst == LCD_IDLE));
                    if (hit != 0) begin
                        if (m_step == ST_DRAINING) fin_ok = 1;
                        else begin m_step = m_step + 1; m_cnt = 0; end
                    end else if (m_cnt == TIMEOUT) fin_ab = 1;
                    else m_cnt = m_cnt + 1;
                end
                if (fin_ok != 0 || fin_ab != 0) begin
                    m_act = 0;
                    if (m_urg == 0) m_ptr = (m_owner + 1) % NREQ;
                    if (fin_ok != 0) e_done[m_owner] = 1'b1;
                    if (fin_ab != 0) e_err = 1'b1;
                end
            end
            e_busy = (m_act != 0);
        end
        #1;
        if (m_valid != 0) begin
            n_total++;
            if (grant === e_grant && done === e_done && lcd_advance === e_adv && busy === e_busy &&
                column_write === e_col && line_write === e_line && timeout_err === e_err)
                n_pass++;
            else
                $display("FAIL cycle_model @%0t: got g=%b d=%b adv=%b busy=%b col=%0d line=%0d err=%b, want g=%b d=%b adv=%b busy=%b col=%0d line=%0d err=%b",
                         $time, grant, done, lcd_advance, busy, column_write, line_write, timeout_err,
                         e_grant, e_done, e_adv, e_busy, e_col, e_line, e_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    int lcd_auto = 0, lcd_ph = 0, lcd_cnt = 0, cycles = 0;
    logic [NREQ-1:0] glog[$];
    logic [NREQ-1:0] dlog[$];
    int gcyc[$];
    int dcyc[$];

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, exp);
    endtask

    // One cycle: advance to the negedge, log pulses, run the simple LCD model
    task automatic cyc();
        @(negedge clock);
        cycles++;
        if (grant != '0) begin glog.push_back(grant); gcyc.push_back(cycles); end
        if (done  != '0) begin dlog.push_back(done);  dcyc.push_back(cycles); end
        if (lcd_auto != 0) begin
            case (lcd_ph)
                0: if (lcd_advance) begin lcd_state = LCD_WRITE; lcd_ph = 1; lcd_cnt = 0; end
                1: begin lcd_cnt++; if (lcd_cnt == 2) begin lcd_state = LCD_DISP0; lcd_ph = 2; lcd_cnt = 0; end end
                default: begin lcd_cnt++; if (lcd_cnt == 2) begin lcd_state = LCD_IDLE; lcd_ph = 0; lcd_cnt = 0; end end
            endcase
        end
    endtask

    task automatic wait_grant(input string nm, output logic [NREQ-1:0] g);
        int k;
        k = 0;
        while (grant == '0 && k < 200) begin cyc(); k++; end
        g = grant;
        if (grant == '0) begin n_total++; $display("FAIL %s: no grant within 200 cycles", nm); end
    endtask

    task automatic wait_done(input string nm, output logic [NREQ-1:0] d);
        int k;
        k = 0;
        while (done == '0 && k < 200) begin cyc(); k++; end
        d = done;
        if (done == '0) begin n_total++; $display("FAIL %s: no done within 200 cycles", nm); end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        cyc(); cyc();
        reset = 1'b0; lcd_state = LCD_IDLE; lcd_ph = 0; lcd_cnt = 0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_grant"}, int'(grant), 0);
        chk({nm, "_done"},  int'(done), 0);
        chk({nm, "_adv"},   int'(lcd_advance), 0);
        chk({nm, "_busy"},  int'(busy), 0);
        chk({nm, "_col"},   int'(column_write), 0);
        chk({nm, "_line"},  int'(line_write), 0);
        chk({nm, "_err"},   int'(timeout_err), 0);
    endtask

    // ---------------- directed scenarios ----------------
    logic [NREQ-1:0] g, d, g1, g2;
    logic [NREQ-1:0] exp_rr [4];
    int clamp_tab [5][4];
    int dn0, k;

    initial begin
        reset = 1'b1; req = '0; req_column = '0; req_line = '0; lcd_state = LCD_IDLE;
        cyc(); cyc();
        chk_all_zero("reset");
        reset = 1'b0;

        // T1: single request, literal latency and region
        lcd_auto = 1;
        req = 3'b010; req_column = {8'd0, 8'd40, 8'd0}; req_line = {4'd0, 4'd2, 4'd0};
        cyc();
        chk("t1_grant", int'(grant), 2);
        req = '0;
        cyc();
        chk("t1_adv", int'(lcd_advance), 1);
        chk("t1_col", int'(column_write), 40);
        chk("t1_line", int'(line_write), 2);
        wait_done("t1_done_wait", d);
        chk("t1_done", int'(d), 2);
        cyc();
        chk("t1_done_pulse", int'(done), 0);

        // T2: all three requesting, round-robin order from pointer 0
        do_reset();
        glog.delete(); dlog.delete(); gcyc.delete(); dcyc.delete();
        req = 3'b111; req_column = {8'd30, 8'd20, 8'd10}; req_line = {4'd3, 4'd2, 4'd1};
        k = 0;
        while (glog.size() < 4 && k < 300) begin cyc(); k++; end
        req = '0;
        k = 0;
        while (dlog.size() < 4 && k < 300) begin cyc(); k++; end
        chk("rr_grants", glog.size(), 4);
        chk("rr_dones", dlog.size(), 4);
`ifdef LCD_SCHED_URGENT_EN
        exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) chk($sformatf("rr_order%0d", i), int'(glog[i]), int'(exp_rr[i]));
        for (int i = 0; i < 3; i++)
            if (i + 1 < gcyc.size() && i < dcyc.size())
                chk($sformatf("rr_done_before_grant%0d", i), int'(dcyc[i] < gcyc[i+1]), 1);

        // T3: clamp table {col, line, expected col, expected line}
        clamp_tab = '{'{200, 15, 129, 8}, '{129, 8, 129, 8}, '{130, 9, 129, 8},
                      '{128, 7, 128, 7}, '{255, 0, 129, 0}};
        for (int i = 0; i < 5; i++) begin
            req_column[7:0] = 8'(clamp_tab[i][0]);
            req_line[3:0]   = 4'(clamp_tab[i][1]);
            req = 3'b001;
            wait_grant("clamp_grant_wait", g);
            req = '0;
            chk($sformatf("clamp%0d_col", i), int'(column_write), clamp_tab[i][2]);
            chk($sformatf("clamp%0d_line", i), int'(line_write), clamp_tab[i][3]);
            wait_done("clamp_done_wait", d);
        end

        // T4: LCD never leaves IDLE after advance -> timeout
        lcd_auto = 0; lcd_state = LCD_IDLE;
        req_column[15:8] = 8'd77; req_line[7:4] = 4'd5;
        req = 3'b010;
        wait_grant("to_grant_wait", g);
        req = '0;
        dn0 = dlog.size();
        k = 0;
        while (!timeout_err && k < 5000) begin cyc(); k++; end
        chk("to_err", int'(timeout_err), 1);
        chk("to_busy", int'(busy), 0);
        chk("to_no_done", dlog.size(), dn0);
        chk("to_col_hold", int'(column_write), 77);
        lcd_auto = 1;
        req = 3'b001;
        wait_grant("to_next_grant_wait", g);
        req = '0;
        chk("to_next_grant", int'(g), 1);
        wait_done("to_next_done_wait", d);
        chk("to_next_done", int'(d), 1);

        // T5: reset while waiting for the LCD to leave WRITE
        do_reset();
        lcd_auto = 1;
        req = 3'b001;
        wait_grant("rst_g0_wait", g); req = '0;
        wait_done("rst_d0_wait", d);
        req = 3'b100;
        wait_grant("rst_g1_wait", g); req = '0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk_all_zero("midrst");
        reset = 1'b0; lcd_auto = 0; lcd_ph = 0; lcd_state = LCD_IDLE;
        req = 3'b011;
        wait_grant("midrst_grant_wait", g);
        req = '0;
        chk("midrst_grant", int'(g), 1);
        // LCD reports ERROR mid-refresh -> immediate abort
        dn0 = dlog.size();
        cyc();
        lcd_state = LCD_ERROR;
        cyc();
        chk("lcderr_err", int'(timeout_err), 1);
        chk("lcderr_busy", int'(busy), 0);
        lcd_state = LCD_IDLE;
        cyc();
        chk("lcderr_no_done", dlog.size(), dn0);

        // T6: pointer at 1, requests 0 and 1 together
        do_reset();
        lcd_auto = 1;
        req = 3'b001;
        wait_grant("pri_g0_wait", g); req = '0;
        wait_done("pri_d0_wait", d);
        req = 3'b011;
        wait_grant("pri_g1_wait", g1);
        req = req & ~g1;
        wait_done("pri_d1_wait", d);
        wait_grant("pri_g2_wait", g2);
        req = '0;
        wait_done("pri_d2_wait", d);
`ifdef LCD_SCHED_URGENT_EN
        chk("pri_first", int'(g1), 1);
        chk("pri_second", int'(g2), 2);
`else
        chk("pri_first", int'(g1), 2);
        chk("pri_second", int'(g2), 1);
`endif

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
- Shares the LCD write path between NUM_REQ display producers (speed, distance, elapsed time, and so on).
- Watches the LCD state-machine state code and waits for IDLE.
- Picks one requester round-robin, drives column_write/line_write with that requester's clamped region, and pulses lcd_advance to move the LCD SM from IDLE to WRITE.
- Tracks the refresh until the LCD SM returns to IDLE, then signals done.
- The top level ORs lcd_advance into the LCD SM change_state input.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- COL_MAX, 129: column clamp value.
- LINE_MAX, 8: line clamp value.
- TIMEOUT, 4095: maximum cycles spent in any wait state before abort (12-bit counter).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per producer; held until grant.
- req_column  in  NUM_REQ*8  per-requester column count, requester i at bits [8i+7:8i].
- req_line  in  NUM_REQ*4  per-requester line count, requester i at bits [4i+3:4i].
- lcd_state  in  8  current LCD SM state code.
- column_write  out  8  registered, clamped column limit for the LCD SM.
- line_write  out  4  registered, clamped line limit for the LCD SM.
- lcd_advance  out  1  one-cycle pulse requesting IDLE->WRITE.
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- done  out  NUM_REQ  one-hot, one-cycle pulse when that requester's refresh completes.
- busy  out  1  high in every state except S_IDLE.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: FSM=S_IDLE, column_write=0, line_write=0, lcd_advance=0, grant=0, done=0, busy=0, timeout_err=0, round-robin pointer=0, timer=0.
- S_IDLE:
  - Condition to leave: lcd_state==LCD_IDLE and |req.
  - Winner: the first set bit scanning upward from the pointer, with wrap-around.
  - Actions on the same edge: latch the winner index, load column_write=min(req_column[w],COL_MAX) and line_write=min(req_line[w],LINE_MAX), assert grant[w] for one cycle, go to S_ADV.
  - Clamping is unsigned.
  - Requests seen while lcd_state!=LCD_IDLE are held and not dropped.
- S_ADV:
  - lcd_advance=1 for exactly this cycle, then go to S_WAIT_WR.
  - Latency from req/idle seen to lcd_advance is 2 cycles.
- S_WAIT_WR: when lcd_state==LCD_WRITE, go to S_WAIT_RUN.
- S_WAIT_RUN: when lcd_state!=LCD_WRITE, go to S_WAIT_IDLE.
- S_WAIT_IDLE:
  - When lcd_state==LCD_IDLE: done[w]=1 for one cycle, pointer=(w+1) mod NUM_REQ, go to S_IDLE.
  - The next grant is at least 1 cycle later.
- Timer:
  - Clears on entry to each wait state and increments each cycle spent in one.
  - At timer==TIMEOUT: set timeout_err, go to S_IDLE with no done pulse, pointer=(w+1) mod NUM_REQ, column_write/line_write hold their values.
- Output stability: column_write/line_write change only on a grant edge and stay stable through the whole refresh.
- Requests during a refresh: req changes on any line, including the active requester dropping req, have no effect until S_IDLE.
- Any lcd_state equal to LCD_ERROR while busy is treated as a timeout immediately.
- Reset asserted mid-operation returns everything to reset values on the next edge; no done pulse is issued.

Optional Feature:
- Macro: LCD_SCHED_URGENT_EN.
- Defined:
  - Requester 0 is fixed highest priority: if req[0] is set in S_IDLE it wins regardless of the pointer.
  - Its grant does not move the pointer, so the others keep their round-robin order.
- Undefined: pure round-robin across all requesters including 0.

Decomposition:
- Shared defines package lcd_defs holds the LCD SM state-code constants (LCD_IDLE, LCD_WRITE, LCD_ERROR), reused with the LCD SM.
- Scheduler FSM state encodings are local localparams.
- One sub-module, lcd_rr_arbiter: combinational. Inputs req and pointer; outputs one-hot winner and a binary index.
- The FSM, clamp and timer stay in the top module.

Test Plan:
- Reset, then lcd_state=LCD_IDLE, req=3'b010, col=40, line=2 -> grant=010 at cycle +1, lcd_advance at +2, column_write=40, line_write=2. Step lcd_state WRITE -> DISP0 -> IDLE -> done=010 one cycle.
- req=3'b111 held, LCD model cycling -> grant order 001, 010, 100, 001; each done precedes the next grant.
- req_column=200, req_line=15 -> column_write=129, line_write=8.
- lcd_state stuck at LCD_IDLE after lcd_advance for 4096 cycles -> timeout_err=1, busy=0, no done, next grant serviced normally.
- reset asserted while in S_WAIT_RUN -> next cycle all outputs 0, pointer=0; req=001 afterward -> grant=001.
- With LCD_SCHED_URGENT_EN, pointer at 1, req=3'b011 -> grant=001 first, then 010; without the macro -> 010 first.
